// File: rtl/monopix_readout_pkg.sv
// Shared types and helpers for the MONOPIX matrix/readout model.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package monopix_readout_pkg;

    localparam int COL_W  = 6;
    localparam int ROW_W  = 9;
    localparam int TS_W   = 6;
    localparam int WORD_W = COL_W + ROW_W + 2 * TS_W;

    // Serialised hit word, MSB (col) first.
    typedef struct packed {
        logic [COL_W-1:0] col;
        logic [ROW_W-1:0] row;
        logic [TS_W-1:0]  le;
        logic [TS_W-1:0]  te;
    } hit_word_t;

    // Per-column slice of the active configuration.
    typedef struct packed {
        logic en_col;
        logic inj_col;
    } col_cfg_t;

    localparam col_cfg_t COL_CFG_DEFAULT = '{en_col: 1'b1, inj_col: 1'b0};
    localparam logic     INJ_ROW_DEFAULT = 1'b0;

    typedef enum logic [1:0] {
        PIX_IDLE    = 2'd0,
        PIX_HIGH    = 2'd1,
        PIX_PENDING = 2'd2
    } pix_state_t;

    function automatic logic [TS_W-1:0] gray(input logic [TS_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [TS_W-1:0] bin(input logic [TS_W-1:0] g);
        logic [TS_W-1:0] b;
        b[TS_W-1] = g[TS_W-1];
        for (int i = TS_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/monopix_pixel.sv
// One pixel: registers the hit, time-stamps leading/trailing edge, holds it until read.
// Latency: edge sampled at clock k is time-stamped at clock k+1; PENDING visible right after the TE capture.
// Backpressure: none; edges arriving while HIGH or PENDING are dropped.
// Ports: clk_bx/reset clock and async reset; hit effective discriminator level;
//        ts current Gray BCID; clear read grant; pending/le/te stored hit.
module monopix_pixel
    import monopix_readout_pkg::*;
(
    input  logic            clk_bx,
    input  logic            reset,
    input  logic            hit,
    input  logic [TS_W-1:0] ts,
    input  logic            clear,
    output logic            pending,
    output logic [TS_W-1:0] le,
    output logic [TS_W-1:0] te
);

    logic       hit_q;
    logic       hit_d;
    logic       rise;
    logic       fall;
    pix_state_t state;
    pix_state_t state_nxt;

    always_ff @(posedge clk_bx or posedge reset) begin
        if (reset) begin
            hit_q <= 1'b0;
            hit_d <= 1'b0;
        end else begin
            hit_q <= hit;
            hit_d <= hit_q;
        end
    end

    assign rise = hit_q & ~hit_d;
    assign fall = ~hit_q & hit_d;

    always_ff @(posedge clk_bx or posedge reset) begin
        if (reset) begin
            state <= PIX_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            PIX_IDLE:    if (rise)  state_nxt = PIX_HIGH;
            PIX_HIGH:    if (fall)  state_nxt = PIX_PENDING;
            PIX_PENDING: if (clear) state_nxt = PIX_IDLE;
            default:                state_nxt = PIX_IDLE;
        endcase
    end

    always_comb begin
        pending = (state == PIX_PENDING);
    end

    always_ff @(posedge clk_bx or posedge reset) begin
        if (reset) begin
            le <= '0;
            te <= '0;
        end else begin
            if (state == PIX_IDLE && rise) le <= ts;
            if (state == PIX_HIGH && fall) te <= ts;
        end
    end

endmodule

// File: rtl/monopix_readout.sv
// MONOPIX matrix + readout: config chain, BCID, pixel array, freeze/priority arbiter, serialiser.
// Latency: TOKEN 2 clocks after PENDING; word MSB on OUT_PAD 3 clocks after the READ rising edge.
// Backpressure: none; a READ edge mid-word restarts the serialiser with the new word.
// Ports: CLK_BX_PAD/RESET_PAD clock and async reset; RESET_BCID_PAD BCID clear;
//        DEF_CONF/CONF_SHIFT/SI_CONF/LD_CONF config chain; HIT[row*N_COL+col], PULSE_PAD (active-low);
//        FREEZE_PAD/READ_PAD readout control; TOKEN_PAD hit pending; OUT_PAD serial word.
module monopix_readout
    import monopix_readout_pkg::*;
#(
    parameter int N_COL = 4,
    parameter int N_ROW = 8
) (
    input  logic                   CLK_BX_PAD,
    input  logic                   RESET_PAD,
    input  logic                   RESET_BCID_PAD,
    input  logic                   DEF_CONF_PAD,
    input  logic                   CONF_SHIFT_PAD,
    input  logic                   SI_CONF_PAD,
    input  logic                   LD_CONF_PAD,
    input  logic [N_ROW*N_COL-1:0] HIT,
    input  logic                   PULSE_PAD,
    input  logic                   FREEZE_PAD,
    input  logic                   READ_PAD,
    output logic                   TOKEN_PAD,
    output logic                   OUT_PAD
);

    localparam int N_PIX  = N_ROW * N_COL;
    localparam int CONF_W = 2 * N_COL + N_ROW;

    // Two idle clocks after the READ edge, then 27 data bits, then a return to 0.
    localparam logic [4:0] SER_START = 5'd30;
    localparam logic [4:0] SER_MSB   = 5'd28;
    localparam logic [4:0] SER_LSB   = 5'd2;

    // ---------------- configuration ----------------
    logic [CONF_W-1:0] conf_sr;
    col_cfg_t          cfg_col [N_COL];
    logic [N_ROW-1:0]  cfg_inj_row;

    always_ff @(posedge CLK_BX_PAD or posedge RESET_PAD) begin
        if (RESET_PAD) begin
            conf_sr     <= '0;
            cfg_inj_row <= {N_ROW{INJ_ROW_DEFAULT}};
            for (int c = 0; c < N_COL; c++) cfg_col[c] <= COL_CFG_DEFAULT;
        end else begin
            if (CONF_SHIFT_PAD) conf_sr <= {conf_sr[CONF_W-2:0], SI_CONF_PAD};
            if (DEF_CONF_PAD) begin
                cfg_inj_row <= {N_ROW{INJ_ROW_DEFAULT}};
                for (int c = 0; c < N_COL; c++) cfg_col[c] <= COL_CFG_DEFAULT;
            end else if (LD_CONF_PAD) begin
                // Chain layout (MSB first): EN_COL, INJ_COL, INJ_ROW.
                cfg_inj_row <= conf_sr[N_ROW-1:0];
                for (int c = 0; c < N_COL; c++) begin
                    cfg_col[c].en_col  <= conf_sr[N_ROW+N_COL+c];
                    cfg_col[c].inj_col <= conf_sr[N_ROW+c];
                end
            end
        end
    end

    // ---------------- BCID ----------------
    logic [TS_W-1:0] bcid;
    logic [TS_W-1:0] ts_gray;

    always_ff @(posedge CLK_BX_PAD or posedge RESET_PAD) begin
        if (RESET_PAD)           bcid <= '0;
        else if (RESET_BCID_PAD) bcid <= '0;
        else                     bcid <= bcid + 1'b1;
    end

    assign ts_gray = gray(bcid);

    // ---------------- pixel array ----------------
    logic [N_PIX-1:0] hit_eff;
    logic [N_PIX-1:0] pending;
    logic [N_PIX-1:0] grant;
    logic [TS_W-1:0]  pix_le [N_PIX];
    logic [TS_W-1:0]  pix_te [N_PIX];

    for (genvar r = 0; r < N_ROW; r++) begin : g_row
        for (genvar c = 0; c < N_COL; c++) begin : g_col
            localparam int P = r * N_COL + c;
            // Injection only while PULSE_PAD is low; EN_COL gates both sources.
            assign hit_eff[P] = (HIT[P] | (cfg_col[c].inj_col & cfg_inj_row[r] & ~PULSE_PAD))
                                & cfg_col[c].en_col;
            monopix_pixel u_pix (
                .clk_bx  (CLK_BX_PAD),
                .reset   (RESET_PAD),
                .hit     (hit_eff[P]),
                .ts      (ts_gray),
                .clear   (grant[P]),
                .pending (pending[P]),
                .le      (pix_le[P]),
                .te      (pix_te[P])
            );
        end
    end

    // ---------------- eligible set and token ----------------
    logic             freeze_q;
    logic [N_PIX-1:0] elig_q;

    // The first frozen cycle still loads from pending, which is the snapshot;
    // afterwards the set only shrinks by reads until FREEZE drops.
    always_ff @(posedge CLK_BX_PAD or posedge RESET_PAD) begin
        if (RESET_PAD) begin
            freeze_q  <= 1'b0;
            elig_q    <= '0;
            TOKEN_PAD <= 1'b0;
        end else begin
            freeze_q  <= FREEZE_PAD;
            elig_q    <= (FREEZE_PAD && freeze_q) ? (elig_q & ~grant) : (pending & ~grant);
            TOKEN_PAD <= |elig_q;
        end
    end

    // ---------------- arbiter ----------------
    logic      read_q;
    logic      read_rise;
    logic      sel_vld;
    hit_word_t sel_word;

    assign read_rise = READ_PAD & ~read_q;

    // Column-major scan: lowest column wins, then lowest row.
    always_comb begin
        sel_vld  = 1'b0;
        sel_word = '0;
        grant    = '0;
        for (int c = 0; c < N_COL; c++) begin
            for (int r = 0; r < N_ROW; r++) begin
                if (!sel_vld && elig_q[r*N_COL+c]) begin
                    sel_vld              = 1'b1;
                    sel_word.col         = COL_W'(c);
                    sel_word.row         = ROW_W'(r);
                    sel_word.le          = pix_le[r*N_COL+c];
                    sel_word.te          = pix_te[r*N_COL+c];
                    grant[r*N_COL+c]     = read_rise;
                end
            end
        end
    end

    // ---------------- serialiser ----------------
    logic [4:0]        ser_cnt;
    logic [WORD_W-1:0] ser_sr;

    always_ff @(posedge CLK_BX_PAD or posedge RESET_PAD) begin
        if (RESET_PAD) begin
            read_q  <= 1'b0;
            ser_cnt <= '0;
            ser_sr  <= '0;
            OUT_PAD <= 1'b0;
        end else begin
            read_q <= READ_PAD;
            if (read_rise) begin
                ser_sr  <= sel_word;
                ser_cnt <= SER_START;
                OUT_PAD <= 1'b0;
            end else if (ser_cnt != 5'd0) begin
                ser_cnt <= ser_cnt - 1'b1;
                if (ser_cnt <= SER_MSB && ser_cnt >= SER_LSB) begin
                    OUT_PAD <= ser_sr[WORD_W-1];
                    ser_sr  <= {ser_sr[WORD_W-2:0], 1'b0};
                end else begin
                    OUT_PAD <= 1'b0;
                end
            end else begin
                OUT_PAD <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_monopix_readout.sv
module tb_monopix_readout;

    localparam int N_COL  = 4;
    localparam int N_ROW  = 8;
    localparam int CONF_W = 2 * N_COL + N_ROW;

    logic                   CLK_BX_PAD     = 1'b0;
    logic                   RESET_PAD      = 1'b1;
    logic                   RESET_BCID_PAD = 1'b0;
    logic                   DEF_CONF_PAD   = 1'b0;
    logic                   CONF_SHIFT_PAD = 1'b0;
    logic                   SI_CONF_PAD    = 1'b0;
    logic                   LD_CONF_PAD    = 1'b0;
    logic [N_ROW*N_COL-1:0] HIT            = '0;
    logic                   PULSE_PAD      = 1'b1;
    logic                   FREEZE_PAD     = 1'b0;
    logic                   READ_PAD       = 1'b0;
    logic                   TOKEN_PAD;
    logic                   OUT_PAD;

    int n_checks = 0;
    int n_fail   = 0;

    logic [26:0] exp_q  [$];
    string       name_q [$];

    monopix_readout #(.N_COL(N_COL), .N_ROW(N_ROW)) dut (
        .CLK_BX_PAD     (CLK_BX_PAD),
        .RESET_PAD      (RESET_PAD),
        .RESET_BCID_PAD (RESET_BCID_PAD),
        .DEF_CONF_PAD   (DEF_CONF_PAD),
        .CONF_SHIFT_PAD (CONF_SHIFT_PAD),
        .SI_CONF_PAD    (SI_CONF_PAD),
        .LD_CONF_PAD    (LD_CONF_PAD),
        .HIT            (HIT),
        .PULSE_PAD      (PULSE_PAD),
        .FREEZE_PAD     (FREEZE_PAD),
        .READ_PAD       (READ_PAD),
        .TOKEN_PAD      (TOKEN_PAD),
        .OUT_PAD        (OUT_PAD)
    );

    always #5 CLK_BX_PAD = ~CLK_BX_PAD;

    task automatic check(input string name, input logic [26:0] act, input logic [26:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // All stimulus tasks start and end 1 time unit after a rising edge.
    task automatic step(input int n);
        repeat (n) @(posedge CLK_BX_PAD);
        #1;
    endtask

    // After return, the BCID value sampled at the k-th following edge is k-1.
    task automatic clear_bcid();
        RESET_BCID_PAD = 1'b1;
        step(1);
        RESET_BCID_PAD = 1'b0;
    endtask

    task automatic load_conf(input logic [CONF_W-1:0] v);
        for (int i = CONF_W - 1; i >= 0; i--) begin
            CONF_SHIFT_PAD = 1'b1;
            SI_CONF_PAD    = v[i];
            step(1);
        end
        CONF_SHIFT_PAD = 1'b0;
        SI_CONF_PAD    = 1'b0;
        LD_CONF_PAD    = 1'b1;
        step(1);
        LD_CONF_PAD    = 1'b0;
    endtask

    task automatic do_read(input logic [26:0] w, input string name);
        exp_q.push_back(w);
        name_q.push_back(name);
        READ_PAD = 1'b1;
        step(1);
        READ_PAD = 1'b0;
        step(34);
    endtask

    task automatic pulse_hit(input int idx, input int width);
        HIT[idx] = 1'b1;
        step(width);
        HIT[idx] = 1'b0;
    endtask

    // Monitor: acts as the off-chip controller, deserialising one word per READ edge.
    initial begin : monitor
        logic        prev;
        logic        rise;
        logic [26:0] got;
        logic [26:0] exp_w;
        string       nm;
        prev = 1'b0;
        forever begin
            @(posedge CLK_BX_PAD);
            rise = READ_PAD && !prev;
            prev = READ_PAD;
            if (rise) begin
                got = '0;
                repeat (3) @(posedge CLK_BX_PAD);
                for (int i = 0; i < 27; i++) begin
                    @(negedge CLK_BX_PAD);
                    got = {got[25:0], OUT_PAD};
                    @(posedge CLK_BX_PAD);
                end
                @(negedge CLK_BX_PAD);
                check("out_idle_after_word", 27'(OUT_PAD), 27'd0);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_word: got %h, no word was expected", got);
                end else begin
                    exp_w = exp_q.pop_front();
                    nm    = name_q.pop_front();
                    check(nm, got, exp_w);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        repeat (3) @(posedge CLK_BX_PAD);
        #1;
        check("reset_token", 27'(TOKEN_PAD), 27'd0);
        check("reset_out",   27'(OUT_PAD),   27'd0);
        RESET_PAD = 1'b0;
        step(4);
        check("idle_token", 27'(TOKEN_PAD), 27'd0);

        // Single 9-cycle hit on (0,0): LE=gray(1)=1, TE=gray(10)=15.
        clear_bcid();
        pulse_hit(0, 9);
        step(6);
        check("t1_token_set", 27'(TOKEN_PAD), 27'd1);
        FREEZE_PAD = 1'b1;
        step(1);
        do_read({6'd0, 9'd0, 6'd1, 6'd15}, "t1_word");
        check("t1_token_clear", 27'(TOKEN_PAD), 27'd0);
        FREEZE_PAD = 1'b0;
        step(2);

        // Simultaneous hits (2,7) idx 30 and (0,3) idx 12, width 3: LE=1, TE=gray(4)=6.
        clear_bcid();
        HIT[30] = 1'b1;
        HIT[12] = 1'b1;
        step(3);
        HIT[30] = 1'b0;
        HIT[12] = 1'b0;
        step(6);
        do_read({6'd0, 9'd3, 6'd1, 6'd6}, "t2_word_first");
        check("t2_token_between", 27'(TOKEN_PAD), 27'd1);
        do_read({6'd2, 9'd7, 6'd1, 6'd6}, "t2_word_second");
        check("t2_token_clear", 27'(TOKEN_PAD), 27'd0);

        // Injection into (1,5) idx 21, pulse 4 cycles: LE=1, TE=gray(5)=7.
        load_conf({4'b1111, 4'b0010, 8'b0010_0000});
        clear_bcid();
        PULSE_PAD = 1'b0;
        step(4);
        PULSE_PAD = 1'b1;
        step(6);
        check("t3_token_set", 27'(TOKEN_PAD), 27'd1);
        do_read({6'd1, 9'd5, 6'd1, 6'd7}, "t3_inject_word");
        check("t3_single_word", 27'(TOKEN_PAD), 27'd0);

        // Column 3 disabled: hit on (3,0) idx 3 is ignored.
        load_conf({4'b0111, 4'b0000, 8'b0000_0000});
        clear_bcid();
        pulse_hit(3, 2);
        step(6);
        check("t4_disabled_token", 27'(TOKEN_PAD), 27'd0);
        DEF_CONF_PAD = 1'b1;
        step(1);
        DEF_CONF_PAD = 1'b0;
        clear_bcid();
        pulse_hit(3, 2);
        step(6);
        check("t4_default_token", 27'(TOKEN_PAD), 27'd1);
        do_read({6'd3, 9'd0, 6'd1, 6'd2}, "t4_default_word");

        // BCID wrap: start at BCID 62, width 4 on (1,2) idx 9: LE=gray(63)=32, TE=gray(3)=2.
        clear_bcid();
        step(62);
        pulse_hit(9, 4);
        step(6);
        do_read({6'd1, 9'd2, 6'd32, 6'd2}, "t5_wrap_word");
        do_read(27'd0, "t5_empty_word");
        check("t5_token_clear", 27'(TOKEN_PAD), 27'd0);

        // Hit completing while frozen stays ineligible until FREEZE drops; (0,1) idx 4.
        FREEZE_PAD = 1'b1;
        step(2);
        clear_bcid();
        pulse_hit(4, 2);
        step(6);
        check("t6_frozen_token", 27'(TOKEN_PAD), 27'd0);
        FREEZE_PAD = 1'b0;
        step(4);
        check("t6_unfrozen_token", 27'(TOKEN_PAD), 27'd1);
        do_read({6'd0, 9'd1, 6'd1, 6'd2}, "t6_word");
        check("t6_token_clear", 27'(TOKEN_PAD), 27'd0);

        step(10);
        check("words_outstanding", 27'(exp_q.size()), 27'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
